alu_sched: RTL
==============

# alu_sched

Two-requester scheduler and sequencer for the shared 4-bit `alu` datapath. Each requester presents an operand pair and opcode with a valid/ready handshake. The block arbitrates round-robin, registers the winning command, and drives the combinational `alu`. It then returns the 8-bit result tagged with the requester ID through a backpressured response channel. It sits between the two command sources and the single `alu` instance.

## Interface
Parameters:
- `DIVZ_VALUE`, default 8'hFF: result returned for op 3 with b == 0 when divide-by-zero checking is compiled in.

Ports:
- `clk` input 1: single clock; everything is sampled on the rising edge.
- `rst` input 1: reset; asynchronous, active-high.
- `req0_valid` input 1: requester 0 has a command.
- `req0_ready` output 1: requester 0 command accepted this cycle.
- `req0_a` input 4: requester 0 operand a.
- `req0_b` input 4: requester 0 operand b.
- `req0_op` input 3: requester 0 opcode, same encoding as `alu`.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1.
- `rsp_valid` output 1: response holding.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_id` output 1: requester that issued the command.
- `rsp_data` output 8: ALU result.
- `rsp_err` output 1: divide-by-zero flag.
- `busy` output 1: state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `reqN_valid` is high, grant one requester. Assert its `reqN_ready` combinationally in the same cycle.
  - Latch a/b/op and the ID into the command register, then go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - The registered command drives `alu`.
  - Capture `alu` output into `rsp_data`, compute `rsp_err`, then go to RESP.
- RESP:
  - Hold `rsp_valid`=1 with data, ID and err stable until `rsp_ready`=1.
  - On acceptance, go to IDLE. A new grant is possible the following cycle.
- Arbitration:
  - `last_id` register, reset to 1, so requester 0 wins the first contention.
  - Both valid: grant `!last_id`. One valid: grant that one.
  - `last_id` updates on every grant.
- Only one `reqN_ready` is ever high. Both are low outside IDLE.
- Arithmetic follows `alu` exactly: operands zero-extended to 8 bits, results mod 256.
  - op 0: a+b.
  - op 1: a−b, wraps.
  - op 2: a*b.
  - op 3: a/b.
  - op 4: a<<3.
  - op 5: a>>3.
  - op 6: b<<3.
  - op 7: b>>3.
- A requester dropping valid before ready is legal; nothing is latched.

## Timing
- Reset values: `req0_ready`=0, `req1_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=8'h00, `rsp_err`=0, `busy`=0, state IDLE, `last_id`=1.
- Latency: a handshake in cycle T gives `rsp_valid`=1 from cycle T+2.
- Peak throughput is one command per 3 cycles with `rsp_ready` tied high.
- `rsp_ready` high while `rsp_valid` is low has no effect.
- Reset asserted mid-EXEC or mid-RESP discards the command and response immediately (asynchronous). No response is emitted after reset release.
- Simultaneous new request and response acceptance in RESP: the request waits until the IDLE cycle.

## Configuration
- `ALU_SCHED_DIVZ_CHECK_EN` defined:
  - op 3 with registered b == 0 yields `rsp_data`=`DIVZ_VALUE` and `rsp_err`=1.
  - All other ops give `rsp_err`=0.
- Not defined:
  - `rsp_err` is tied 0.
  - `rsp_data` is always the raw `alu` output, and divide-by-zero is unspecified.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_SHL_A=4, OP_SHR_A=5, OP_SHL_B=6, OP_SHR_B=7.
  - FSM state typedef.
  - Command struct {a, b, op, id}.
- One sub-module: the existing `alu`, instantiated once and driven from the command register. Its output is captured in EXEC.

## Test plan
- Reset then single request:
  - req0 a=4'd9, b=4'd6, op 0 handshakes in cycle T.
  - `rsp_valid` rises at T+2 with `rsp_data`=8'd15, `rsp_id`=0, `busy` high through RESP.
- Contention:
  - Both valid continuously, `rsp_ready`=1.
  - Grants alternate 0,1,0,1.
  - req1 a=3, b=5, op 1 returns 8'hFE with id 1.
- Backpressure:
  - `rsp_ready`=0 for 5 cycles after op 2, a=15, b=15.
  - `rsp_data` holds 8'd225 stable, both readies stay 0, and the response is accepted on the first `rsp_ready`=1.
- Shifts:
  - op 4, a=4'hF gives 8'h78.
  - op 5, a=4'h9 gives 8'h01.
  - op 6, b=4'h1 gives 8'h08.
  - op 7, b=4'h7 gives 8'h00.
- Divide:
  - op 3, a=13, b=4 gives 8'd3, `rsp_err`=0.
  - With the macro defined, b=0 gives 8'hFF, `rsp_err`=1.
- Async reset asserted in RESP:
  - All outputs return to reset values without a clock edge.
  - No stale response appears after release, and the next contention grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its two-requester scheduler:
// opcode encoding, scheduler FSM state encoding and the command record.
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_SHL_A = 3'd4;
    localparam logic [2:0] OP_SHR_A = 3'd5;
    localparam logic [2:0] OP_SHL_B = 3'd6;
    localparam logic [2:0] OP_SHR_B = 3'd7;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       id;
    } cmd_t;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU. Operands are zero-extended to 8 bits and the
// result wraps mod 256. A divide by zero returns 0 so the output never
// goes unknown; callers that care about that case handle it themselves.
module alu
    import alu_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [2:0] i_op,
    output logic [7:0] o_y
);

    logic [7:0] w_a;
    logic [7:0] w_b;

    assign w_a = {4'h0, i_a};
    assign w_b = {4'h0, i_b};

    // Opcode decode onto the zero-extended operands
    always_comb begin
        o_y = 8'h00;
        case (i_op)
            OP_ADD:   o_y = w_a + w_b;
            OP_SUB:   o_y = w_a - w_b;
            OP_MUL:   o_y = w_a * w_b;
            OP_DIV:   o_y = (i_b == 4'h0) ? 8'h00 : (w_a / w_b);
            OP_SHL_A: o_y = w_a << 3;
            OP_SHR_A: o_y = w_a >> 3;
            OP_SHL_B: o_y = w_b << 3;
            OP_SHR_B: o_y = w_b >> 3;
            default:  o_y = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler in front of one shared alu.
// IDLE grants and latches a command, EXEC captures the alu result,
// RESP holds the tagged response until the consumer takes it.
// Optional feature macro: ALU_SCHED_DIVZ_CHECK_EN -- when defined, op 3
// with b == 0 returns DIVZ_VALUE and raises rsp_err.
module alu_sched
    import alu_pkg::*;
#(
    parameter logic [7:0] DIVZ_VALUE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    state_t     r_state;
    cmd_t       r_cmd;
    logic       r_last_id;
    logic [7:0] r_rsp_data;
    logic       r_rsp_id;
    logic       r_rsp_err;

    logic       w_idle;
    logic       w_grant;
    logic       w_gnt_id;
    logic [7:0] w_alu_y;
    logic [7:0] w_rsp_data_n;
    logic       w_rsp_err_n;
    cmd_t       w_cmd_n;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_grant = w_idle && (req0_valid || req1_valid);

    // Round-robin pick: on contention the requester not served last wins;
    // otherwise whichever one is asking
    always_comb begin
        w_gnt_id = 1'b0;
        if (req0_valid && req1_valid) w_gnt_id = ~r_last_id;
        else if (req1_valid)          w_gnt_id = 1'b1;
    end

    assign req0_ready = w_grant && !w_gnt_id;
    assign req1_ready = w_grant &&  w_gnt_id;

    // Mux the winning requester's fields into a command record
    always_comb begin
        w_cmd_n = w_gnt_id ? '{a: req1_a, b: req1_b, op: req1_op, id: 1'b1}
                           : '{a: req0_a, b: req0_b, op: req0_op, id: 1'b0};
    end

    alu u_alu (
        .i_a  (r_cmd.a),
        .i_b  (r_cmd.b),
        .i_op (r_cmd.op),
        .o_y  (w_alu_y)
    );

`ifdef ALU_SCHED_DIVZ_CHECK_EN
    logic w_divz;
    assign w_divz       = (r_cmd.op == OP_DIV) && (r_cmd.b == 4'h0);
    assign w_rsp_data_n = w_divz ? DIVZ_VALUE : w_alu_y;
    assign w_rsp_err_n  = w_divz;
`else
    // DIVZ_VALUE only matters with the check compiled in
    logic w_unused_divz;
    assign w_unused_divz = ^DIVZ_VALUE;
    assign w_rsp_data_n  = w_alu_y;
    assign w_rsp_err_n   = 1'b0;
`endif

    // FSM, command register, arbitration history and response register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_last_id  <= 1'b1;
            r_rsp_data <= 8'h00;
            r_rsp_id   <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_cmd     <= w_cmd_n;
                        r_last_id <= w_gnt_id;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_data <= w_rsp_data_n;
                    r_rsp_id   <= r_cmd.id;
                    r_rsp_err  <= w_rsp_err_n;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = !w_idle;

endmodule
